// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Data-memory controller for a processor memory stage. A request (exactly one
//   of MemRead/MemWrite) is sampled in IDLE. The controller then spends
//   WaitStates cycles in WAIT and performs the array access on entry to DONE.
//   DONE lasts one cycle, and MemReady is high for that cycle.
//
//   Handshake: the requester raises MemRead or MemWrite with stable MemAddr and
//   MemData, holds them until MemReady, and drops them in the cycle after
//   MemReady. Inputs are ignored outside IDLE. A request still high in IDLE
//   starts a new access.
//
//   Error cases (MemError is meaningful only while MemReady=1):
//     - address bits above AddrBits nonzero: no array access, a read returns 0
//     - MemRead and MemWrite both high: no access, straight to DONE, and
//       MemOutput is left unchanged
//
//   Optional feature macro: DMEM_STATS_EN adds RdCount/WrCount. These are
//   saturating 16-bit counts of successful in-range reads and writes.
//
// Parameters
//   DataWidth  : data and address width
//   AddrBits   : decoded word-address bits (2**AddrBits words)
//   WaitStates : added wait cycles per access, 0..7
// Ports
//   CLK, RST          : clock, asynchronous active-low reset
//   MemRead, MemWrite : request strobes
//   MemAddr, MemData  : word address, write data
//   MemOutput         : registered read data
//   MemReady          : one-cycle completion pulse
//   MemError          : error flag qualified by MemReady
//   RdCount, WrCount  : (DMEM_STATS_EN only) completion counters
//   dbg_state_o       : current FSM state, for observation
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DataWidth  = 16,
    parameter int AddrBits   = 8,
    parameter int WaitStates = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [DataWidth-1:0] MemAddr,
    input  logic [DataWidth-1:0] MemData,
    output logic [DataWidth-1:0] MemOutput,
    output logic                 MemReady,
    output logic                 MemError,
`ifdef DMEM_STATS_EN
    output logic [15:0]          RdCount,
    output logic [15:0]          WrCount,
`endif
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] WsInit = (WaitStates > 0) ? 3'(WaitStates - 1) : 3'd0;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 rd_q, wr_q;
    logic [DataWidth-1:0] addr_q, data_q;
    logic [DataWidth-1:0] out_q;
    logic                 err_q;

    // The array has no reset; reset must leave its contents intact.
    logic [DataWidth-1:0] mem_q [2**AddrBits];

    // Operands of the access being completed. For the zero-wait path, and for
    // the both-high path, DONE is entered directly from IDLE. The operands are
    // latched on that same edge, so the live inputs are used instead.
    logic                 cur_rd, cur_wr;
    logic [DataWidth-1:0] cur_addr, cur_data;
    logic [AddrBits-1:0]  cur_idx;
    logic                 cur_oor, cur_conflict;
    logic                 enter_done;
    logic                 do_write, do_read;

    always_comb begin
        if (state_q == IDLE) begin
            cur_rd   = MemRead;
            cur_wr   = MemWrite;
            cur_addr = MemAddr;
            cur_data = MemData;
        end else begin
            cur_rd   = rd_q;
            cur_wr   = wr_q;
            cur_addr = addr_q;
            cur_data = data_q;
        end
    end

    assign cur_idx      = cur_addr[AddrBits-1:0];
    assign cur_oor      = (cur_addr >> AddrBits) != '0;
    assign cur_conflict = cur_rd && cur_wr;
    assign enter_done   = (state_q != DONE) && (state_d == DONE);
    assign do_write     = enter_done && cur_wr && !cur_rd && !cur_oor;
    assign do_read      = enter_done && cur_rd && !cur_wr;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MemRead ^ MemWrite) begin
                    if (WaitStates == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WsInit;
                    end
                end else if (MemRead && MemWrite) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE) begin
                rd_q   <= MemRead;
                wr_q   <= MemWrite;
                addr_q <= MemAddr;
                data_q <= MemData;
            end
            if (do_read) begin
                out_q <= cur_oor ? '0 : mem_q[cur_idx];
            end
            // Only set on DONE entry, so it falls again when DONE is left.
            err_q <= enter_done && (cur_oor || cur_conflict);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_write) begin
            mem_q[cur_idx] <= cur_data;
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            if (do_read && !cur_oor && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (do_write && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;
`endif

    assign MemOutput   = out_q;
    assign MemReady    = (state_q == DONE);
    assign MemError    = err_q;
    assign dbg_state_o = state_q;

endmodule
